regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with a per-register pending scoreboard, for the pipelined KGP-RISC datapath. It gives NUM_RD combinational read ports, one writeback port with optional write-to-read bypass, and an issue port that marks destination registers busy until their writeback. After reset it clears storage with a sequential sweep and signals `ready`. It sits between decode (reads and issue) and writeback, and exposes a debug tap register to the board-level display.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports; must be >= 1.
- BYPASS, 1: 1 = same-cycle writeback is forwarded to reads; 0 = no forwarding.
- DEBUG_REG, 12: index driven on `dbg_out`; must be < DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep is done.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational; same packing.
- rd_busy  out  NUM_RD  pending flag of each addressed register.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue strobe; marks `iss_addr` pending.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- dbg_out  out  DATA_W  contents of entry DEBUG_REG.

## Operation
- States:
  - INIT: sweep counter `cnt` (ADDR_W bits). Each cycle clears entry `cnt` and pending bit `cnt`, then increments. When `cnt` reaches DEPTH-1, the FSM moves to RUN.
  - RUN: normal operation.
- `rst` high at an edge forces INIT with `cnt`=0. This applies in any state, including mid-sweep, which restarts the sweep.
- While `ready`=0:
  - `wr_en` and `iss_en` are ignored.
  - `rd_data`, `rd_busy` and `dbg_out` are forced to 0.
- Register 0:
  - Always reads 0 with busy 0.
  - Writes and issues targeting 0 are ignored.
- Write (RUN): with `wr_en` and `wr_addr`!=0, `wr_data` is stored and pending[`wr_addr`] is cleared at the edge.
- Issue (RUN): with `iss_en` and `iss_addr`!=0, pending[`iss_addr`] is set at the edge.
- Issue and write to the same address in the same cycle: the issue wins, so the pending bit ends at 1 and the data is still written.
- Read port k (RUN):
  - If BYPASS=1, `wr_en`, `wr_addr`==`rd_addr`[k] and the address is !=0: `rd_data`[k] = `wr_data` and `rd_busy`[k] = 0.
  - Otherwise `rd_data`[k] = stored entry and `rd_busy`[k] = pending bit.
  - A same-cycle issue never affects the current-cycle `rd_busy`.
- `dbg_out` = stored entry DEBUG_REG, with no bypass.

## Timing
- Reset values at the edge where `rst` is sampled high: `ready`=0, state INIT, `cnt`=0. All outputs read 0.
- Sweep length is DEPTH cycles. Counting the first edge with `rst` low as edge 1, `ready` rises at edge DEPTH (32 for the default configuration) and stays high until the next reset.
- Write latency: stored data is visible on a non-bypassed read the cycle after the `wr_en` edge.
- With BYPASS=1, the written data is visible in the same cycle.
- Issue latency: `rd_busy` rises the cycle after the `iss_en` edge.
- Reads are purely combinational from address to data and busy; there is no read latency.
- Reset mid-operation: the next edge drops `ready`. All contents and pending bits are treated as lost and cleared by the new sweep.

## Test plan
- Assert `rst` for 2 cycles, then release. `ready` must read 0 on edges 1..31 and 1 from edge 32. `rd_data` and `dbg_out` must read 0 throughout.
- After ready, issue to r5, then write r5=0xDEADBEEF two cycles later:
  - `rd_busy` for r5 must be 1 for those 2 cycles.
  - With BYPASS=1, the writeback cycle must show 0xDEADBEEF and busy 0.
- With BYPASS=0, write r7=0x12345678 while port 0 reads r7. The same cycle must show the old value (0); the next cycle must show 0x12345678.
- Issue and write to r3 (0xA5A5A5A5) in the same cycle. Next cycle `rd_busy`=1 and `rd_data`=0xA5A5A5A5.
- Write r0=0xFFFFFFFF and issue r0. Reads of r0 on all ports must return 0 with busy 0.
- Write r12=0x0000002A, so `dbg_out`=0x2A. Assert `rst` on cycle 10 of a subsequent sweep restart. `ready` must stay 0 for 32 cycles after release, and `dbg_out` must read 0 afterwards.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Register file with a per-register pending scoreboard. It has
//            NUM_RD combinational read ports, one writeback port with optional
//            same-cycle bypass, and an issue port that marks destinations busy.
//            After reset a sequential sweep clears storage, then raises ready.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int DEBUG_REG = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [DATA_W-1:0]          dbg_out
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DBG_IDX  = ADDR_W'(DEBUG_REG);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_pend;

    logic                w_run;
    logic                w_wr_ok;
    logic                w_iss_ok;

    // Register 0 is hardwired to zero, so writes and issues to it are dropped.
    assign w_run    = (r_state == ST_RUN);
    assign w_wr_ok  = w_run && wr_en  && (wr_addr  != '0);
    assign w_iss_ok = w_run && iss_en && (iss_addr != '0);

    // Sweep/run control and pending scoreboard; issue is applied last so it
    // beats a same-cycle writeback to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_pend[r_cnt] <= 1'b0;
                    r_cnt         <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_wr_ok) begin
                        r_pend[wr_addr] <= 1'b0;
                    end
                    if (w_iss_ok) begin
                        r_pend[iss_addr] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: cleared entry by entry during the sweep, written back in run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign ready = r_ready;

    // The debug tap shows stored contents only; no forwarding.
    assign dbg_out = r_ready ? r_mem[DBG_IDX] : '0;

    // Read ports: combinational, zero while not ready or addressing r0.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_valid;
        logic              w_hit;

        assign w_addr  = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_valid = r_ready && (w_addr != '0);
        assign w_hit   = (BYPASS != 0) && wr_en && (wr_addr == w_addr);

        assign rd_data[k*DATA_W +: DATA_W] = !w_valid ? '0 :
                                             (w_hit ? wr_data : r_mem[w_addr]);
        assign rd_busy[k] = w_valid && !w_hit && r_pend[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb. Two instances share stimulus:
//            one with write bypass, one without. Port 1 always reads r0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  ra;
    logic [9:0]  rd_addr;

    logic        ready_b,   ready_n;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [31:0] dbg_b,     dbg_n;

    assign rd_addr = {5'd0, ra};

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .DEBUG_REG(12)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_out(dbg_b)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .DEBUG_REG(12)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_out(dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rdy;
        logic [31:0] dbg;
        logic [31:0] d1;   // bypass instance, port 0
        logic        b1;
        logic [31:0] d0;   // no-bypass instance, port 0
        logic        b0;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of inputs just after the edge and queue what both
    // instances must show before the next edge.
    task automatic stim(input string tag, input logic rs,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia, input logic [4:0] raddr,
                        input logic rdy, input logic [31:0] dbg,
                        input logic [31:0] d1, input logic b1,
                        input logic [31:0] d0, input logic b0);
        exp_t x;
        @(posedge clk);
        #1;
        rst = rs; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; ra = raddr;
        x.tag = tag; x.rdy = rdy; x.dbg = dbg;
        x.d1 = d1; x.b1 = b1; x.d0 = d0; x.b0 = b0;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 36; i++) begin
            stim($sformatf("reset_%0d", i), (i < 2), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5,
                 (i >= 34), 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    task automatic test_issue_write();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: stim("r5_issue", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5,
                        1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
                1: stim("r5_busy1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5,
                        1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
                2: stim("r5_busy2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5,
                        1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
                3: stim("r5_wb", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5,
                        1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
                default: stim("r5_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5,
                        1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    task automatic test_no_bypass();
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                stim("r7_wb", 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7,
                     1'b1, 32'h0, 32'h12345678, 1'b0, 32'h0, 1'b0);
            else
                stim("r7_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7,
                     1'b1, 32'h0, 32'h12345678, 1'b0, 32'h12345678, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    task automatic test_issue_write_same();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: stim("r3_iss_wb", 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3,
                        1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
                1: stim("r3_pending", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3,
                        1'b1, 32'h0, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1);
                2: stim("r3_wb2", 1'b0, 1'b1, 5'd3, 32'h5A5A5A5A, 1'b0, 5'd0, 5'd3,
                        1'b1, 32'h0, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5, 1'b1);
                default: stim("r3_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3,
                        1'b1, 32'h0, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 1'b0);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    task automatic test_r0();
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                stim("r0_wr_iss", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,
                     1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            else
                stim("r0_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0,
                     1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: stim("b2b_w1", 1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 5'd1,
                        1'b1, 32'h0, 32'h11, 1'b0, 32'h0, 1'b0);
                1: stim("b2b_w2", 1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd1,
                        1'b1, 32'h0, 32'h11, 1'b0, 32'h11, 1'b0);
                2: stim("b2b_w4_i2", 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd2, 5'd2,
                        1'b1, 32'h0, 32'h22, 1'b0, 32'h22, 1'b0);
                3: stim("b2b_r2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2,
                        1'b1, 32'h0, 32'h22, 1'b1, 32'h22, 1'b1);
                default: stim("b2b_r4", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4,
                        1'b1, 32'h0, 32'h44, 1'b0, 32'h44, 1'b0);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    // Debug tap, then reset mid-run, reset again 10 edges into the new sweep,
    // and try a write/issue during the sweep that must be ignored.
    task automatic test_debug_restart();
        for (int i = 0; i < 49; i++) begin
            case (i)
                0: stim("dbg_wb", 1'b0, 1'b1, 5'd12, 32'h2A, 1'b0, 5'd0, 5'd12,
                        1'b1, 32'h0, 32'h2A, 1'b0, 32'h0, 1'b0);
                1: stim("dbg_iss", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12,
                        1'b1, 32'h2A, 32'h2A, 1'b0, 32'h2A, 1'b0);
                2: stim("dbg_busy", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12,
                        1'b1, 32'h2A, 32'h2A, 1'b1, 32'h2A, 1'b1);
                3: stim("dbg_rst", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12,
                        1'b1, 32'h2A, 32'h2A, 1'b1, 32'h2A, 1'b1);
                default: stim($sformatf("restart_%0d", i), (i == 14),
                        (i == 35), 5'd12, 32'h77, (i == 35), 5'd12, 5'd12,
                        (i >= 47), 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n} !==
                {e.rdy, e.rdy, e.dbg, e.dbg, 32'h0, e.d1, 1'b0, e.b1, 32'h0, e.d0, 1'b0, e.b0}) begin
                errors++;
                $display("FAIL %s: got rdy=%b/%b dbg=%h/%h byp=%h/%b nobyp=%h/%b; want rdy=%b dbg=%h byp=%h/%b nobyp=%h/%b",
                         e.tag, ready_b, ready_n, dbg_b, dbg_n, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n,
                         e.rdy, e.dbg, e.d1, e.b1, e.d0, e.b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; ra = '0;
        test_reset();
        test_issue_write();
        test_no_bypass();
        test_issue_write_same();
        test_r0();
        test_back_to_back();
        test_debug_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
